pipeline_stage_buffer: RTL and testbench
========================================

PIPELINE_STAGE_BUFFER -- requirements
Module: pipeline_stage_buffer

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of the payload carried through the stage.
REQ-002 Parameter: RESET_DATA, default 0, value loaded into every data register on reset.
REQ-003 CLOCK  input  1  clock; all state updates on the rising edge.
REQ-004 RESET  input  1  reset: synchronous, active-high; clock CLOCK.
REQ-005 FLUSH  input  1  synchronous invalidate of all held entries.
REQ-006 IN_VALID  input  1  upstream holds a valid payload on IN_DATA.
REQ-007 IN_READY  output  1  stage accepts IN_DATA this cycle.
REQ-008 IN_DATA  input  DATA_WIDTH  upstream payload.
REQ-009 OUT_VALID  output  1  OUT_DATA holds a valid payload.
REQ-010 OUT_READY  input  1  downstream accepts OUT_DATA this cycle.
REQ-011 OUT_DATA  output  DATA_WIDTH  payload presented downstream.
REQ-012 STALL_COUNT  output  16  saturating count of downstream-stalled cycles.

Function
REQ-013 Accept SHALL occur when IN_VALID && IN_READY, and SHALL be ignored in a cycle where FLUSH=1.
REQ-014 Fire SHALL occur when OUT_VALID && OUT_READY.
REQ-015 Payloads SHALL leave in acceptance order, with no loss and no duplication.
REQ-016 An accepted payload SHALL appear on OUT_DATA with OUT_VALID=1 in the cycle after acceptance (latency 1) when the stage was empty.
REQ-017 While OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_VALID SHALL stay stable.
REQ-018 When empty, OUT_DATA SHALL hold the last presented value; OUT_VALID SHALL be 0.
REQ-019 FLUSH=1 SHALL make the stage empty next cycle, with OUT_VALID=0 and IN_READY=1; a fire in the same cycle still completes downstream.
REQ-020 STALL_COUNT SHALL increment each cycle OUT_VALID=1 && OUT_READY=0, saturating at 0xFFFF.
REQ-021 FLUSH SHALL NOT clear STALL_COUNT.
REQ-022 A stall cycle coinciding with FLUSH SHALL still count.
REQ-023 IN_VALID=1 with IN_READY=0 SHALL have no effect; upstream holds its data.

Reset
REQ-024 RESET SHALL dominate FLUSH and all handshakes; the next state is empty.
REQ-025 Outputs after reset: OUT_VALID=0, OUT_DATA=RESET_DATA, STALL_COUNT=0.
REQ-026 IN_READY after reset SHALL be 1.
REQ-027 Reset mid-transfer SHALL discard all held payloads; the pending accept is lost.

Configuration
REQ-028 Macro PIPELINE_STAGE_SKID_EN defined: two-entry skid buffer with states EMPTY, ONE, TWO; IN_READY is registered, equal to 1 in EMPTY/ONE and 0 in TWO.
REQ-029 Skid transitions: EMPTY+accept->ONE; ONE+accept+fire->ONE (main<=IN_DATA); ONE+accept+!fire->TWO (skid<=IN_DATA); ONE+!accept+fire->EMPTY; TWO+fire->ONE (main<=skid); otherwise hold.
REQ-030 With the skid buffer, sustained throughput SHALL be 1 payload/cycle while OUT_READY=1.
REQ-031 Macro PIPELINE_STAGE_SKID_EN undefined: single entry with states EMPTY, FULL; IN_READY = !OUT_VALID || OUT_READY (combinational); accept+fire in FULL replaces the entry; throughput is 1 payload/cycle.

Verification
REQ-032 Reset, then IN_VALID=1, IN_DATA=0xA5A5A5A5, OUT_READY=1 for one cycle -> next cycle OUT_VALID=1, OUT_DATA=0xA5A5A5A5; STALL_COUNT=0.
REQ-033 Stream 0x1..0x8 back-to-back with OUT_READY=1 -> outputs 0x1..0x8 on consecutive cycles, 8 cycles after the first, no gaps.
REQ-034 Skid build: accept 0x11, 0x22 with OUT_READY=0 -> IN_READY=0 after the second accept; OUT_DATA=0x11 stable; STALL_COUNT increments; raise OUT_READY -> 0x11 then 0x22. Non-skid build: IN_READY=0 after the first accept.
REQ-035 FLUSH=1 with one entry held and IN_VALID=1 (0x33) -> next cycle OUT_VALID=0, IN_READY=1; 0x33 is never output; STALL_COUNT is unchanged by the flush.
REQ-036 Hold OUT_VALID=1, OUT_READY=0 for 70000 cycles -> STALL_COUNT=0xFFFF and holds; RESET -> STALL_COUNT=0, OUT_DATA=RESET_DATA.
REQ-037 Assert RESET together with FLUSH and an accept while in TWO -> next cycle empty, OUT_VALID=0; no held payload is ever output.

Source files
------------

// File: rtl/pipeline_stage_buffer.sv
// Valid/ready pipeline stage: one-entry buffer, or two-entry skid buffer when
// PIPELINE_STAGE_SKID_EN is defined. Also counts downstream-stalled cycles.
module pipeline_stage_buffer #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  FLUSH,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic [15:0]           STALL_COUNT
);

    logic                  accept;
    logic                  fire;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] main_d;
    logic [15:0]           stall_q;
    logic [15:0]           stall_d;

    assign accept      = IN_VALID && IN_READY && !FLUSH;
    assign fire        = OUT_VALID && OUT_READY;
    assign OUT_DATA    = main_q;
    assign STALL_COUNT = stall_q;

`ifdef PIPELINE_STAGE_SKID_EN

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [DATA_WIDTH-1:0] skid_d;

    // Ready comes straight from the state register, so it never depends on OUT_READY.
    assign IN_READY  = (state_q != S_TWO);
    assign OUT_VALID = (state_q != S_EMPTY);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (FLUSH) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d = S_ONE;
                        main_d  = IN_DATA;
                    end
                end
                S_ONE: begin
                    if (accept && fire) begin
                        main_d = IN_DATA;
                    end else if (accept) begin
                        state_d = S_TWO;
                        skid_d  = IN_DATA;
                    end else if (fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (fire) begin
                        state_d = S_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= S_EMPTY;
            skid_q  <= RESET_DATA;
        end else begin
            state_q <= state_d;
            skid_q  <= skid_d;
        end
    end

`else

    typedef enum logic {
        S_EMPTY,
        S_FULL
    } state_t;

    state_t state_q;
    state_t state_d;

    assign OUT_VALID = (state_q == S_FULL);
    assign IN_READY  = !OUT_VALID || OUT_READY;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (FLUSH) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d = S_FULL;
                        main_d  = IN_DATA;
                    end
                end
                S_FULL: begin
                    // Accept while full implies a fire: the new payload replaces the old.
                    if (accept) begin
                        main_d = IN_DATA;
                    end else if (fire) begin
                        state_d = S_EMPTY;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

`endif

    always_comb begin
        stall_d = stall_q;
        if (OUT_VALID && !OUT_READY && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            main_q  <= RESET_DATA;
            stall_q <= '0;
        end else begin
            main_q  <= main_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Scoreboard bench for pipeline_stage_buffer: directed scenarios plus random
// traffic, checked against a queue-based model of the stage.
module tb_pipeline_stage_buffer;

    localparam logic [31:0] RST_VAL = 32'hDEADBEEF;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        FLUSH = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] IN_DATA = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [31:0] OUT_DATA;
    logic [15:0] STALL_COUNT;

    pipeline_stage_buffer #(
        .DATA_WIDTH(32),
        .RESET_DATA(RST_VAL)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .FLUSH(FLUSH),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OUT_DATA(OUT_DATA),
        .STALL_COUNT(STALL_COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    int n_tests = 0;
    int n_fail  = 0;
    int fire_cnt = 0;
    logic acc_last = 1'b0;

    // Model state: queued payloads in order, stall counter, last shown value.
    logic [31:0] mq[$];
    int          mstall = 0;
    logic [31:0] mlast = RST_VAL;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares the DUT against the model, then advances the model.
    always @(negedge CLOCK) begin
        logic        mvalid;
        logic        mready;
        logic [31:0] exp_d;
        mvalid = (mq.size() > 0);
`ifdef PIPELINE_STAGE_SKID_EN
        mready = (mq.size() < 2);
`else
        mready = !mvalid || OUT_READY;
`endif
        chk("in_ready", {31'd0, IN_READY}, {31'd0, mready});
        chk("out_valid", {31'd0, OUT_VALID}, {31'd0, mvalid});
        chk("stall_count", {16'd0, STALL_COUNT}, mstall);
        if (mvalid) mlast = mq[0];
        if (!mvalid) chk("out_data_hold", OUT_DATA, mlast);
        if (RESET) begin
            mq.delete();
            mstall = 0;
            mlast = RST_VAL;
        end else begin
            if (mvalid && !OUT_READY && mstall < 65535) mstall++;
            if (OUT_VALID && OUT_READY) begin
                fire_cnt++;
                if (mq.size() == 0) begin
                    chk("spurious_fire", OUT_DATA, 32'hFFFF_FFFF ^ OUT_DATA);
                end else begin
                    exp_d = mq.pop_front();
                    chk("fire_data", OUT_DATA, exp_d);
                end
            end
            if (FLUSH) mq.delete();
            else if (IN_VALID && mready) mq.push_back(IN_DATA);
        end
    end

    task automatic cycle();
        @(negedge CLOCK);
        acc_last = IN_VALID && IN_READY && !FLUSH && !RESET;
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        int f0;
        RESET = 1'b1;
        cycle();
        cycle();
        RESET = 1'b0;
        chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("rst_in_ready", {31'd0, IN_READY}, 32'd1);
        chk("rst_out_data", OUT_DATA, RST_VAL);
        chk("rst_stall", {16'd0, STALL_COUNT}, 32'd0);

        // Single transfer, latency 1
        IN_VALID = 1'b1;
        IN_DATA = 32'hA5A5A5A5;
        OUT_READY = 1'b1;
        cycle();
        IN_VALID = 1'b0;
        chk("lat1_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("lat1_data", OUT_DATA, 32'hA5A5A5A5);
        chk("lat1_stall", {16'd0, STALL_COUNT}, 32'd0);
        cycle();

        // Back-to-back stream, no gaps
        f0 = fire_cnt;
        for (int i = 1; i <= 8; i++) begin
            IN_VALID = 1'b1;
            IN_DATA = i;
            cycle();
        end
        IN_VALID = 1'b0;
        cycle();
        chk("stream_fires", fire_cnt - f0, 32'd8);

        // Backpressure
        OUT_READY = 1'b0;
        IN_VALID = 1'b1;
        IN_DATA = 32'h11;
        cycle();
        IN_DATA = 32'h22;
        cycle();
        cycle();
        cycle();
        chk("bp_in_ready", {31'd0, IN_READY}, 32'd0);
        chk("bp_out_data", OUT_DATA, 32'h11);
        chk("bp_stall", {16'd0, STALL_COUNT}, 32'd3);
        f0 = fire_cnt;
        OUT_READY = 1'b1;
`ifdef PIPELINE_STAGE_SKID_EN
        IN_VALID = 1'b0;
        cycle();
`else
        cycle();
        IN_VALID = 1'b0;
`endif
        cycle();
        cycle();
        chk("bp_drain", fire_cnt - f0, 32'd2);

        // Flush with an entry held and a pending accept
        OUT_READY = 1'b0;
        IN_VALID = 1'b1;
        IN_DATA = 32'h44;
        cycle();
        FLUSH = 1'b1;
        IN_DATA = 32'h33;
        cycle();
        FLUSH = 1'b0;
        IN_VALID = 1'b0;
        chk("flush_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("flush_ready", {31'd0, IN_READY}, 32'd1);
        chk("flush_stall", {16'd0, STALL_COUNT}, 32'd4);
        OUT_READY = 1'b1;
        cycle();
        cycle();

        // Reset beats flush and accept while holding data
        OUT_READY = 1'b0;
        IN_VALID = 1'b1;
        IN_DATA = 32'h55;
        cycle();
        IN_DATA = 32'h66;
        cycle();
        RESET = 1'b1;
        FLUSH = 1'b1;
        IN_DATA = 32'h77;
        cycle();
        RESET = 1'b0;
        FLUSH = 1'b0;
        IN_VALID = 1'b0;
        chk("rstf_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("rstf_data", OUT_DATA, RST_VAL);
        chk("rstf_stall", {16'd0, STALL_COUNT}, 32'd0);
        OUT_READY = 1'b1;
        repeat (3) cycle();

        // Random traffic; upstream holds data until accepted
        acc_last = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (!IN_VALID || acc_last) begin
                IN_VALID = ($urandom_range(3) != 0);
                IN_DATA = $urandom;
            end
            OUT_READY = ($urandom_range(2) != 0);
            FLUSH = ($urandom_range(24) == 0);
            RESET = ($urandom_range(99) == 0);
            cycle();
        end
        RESET = 1'b1;
        FLUSH = 1'b0;
        IN_VALID = 1'b0;
        cycle();
        RESET = 1'b0;

        // Stall counter saturation
        OUT_READY = 1'b0;
        IN_VALID = 1'b1;
        IN_DATA = 32'h99;
        cycle();
        IN_VALID = 1'b0;
        repeat (66000) cycle();
        chk("sat_stall", {16'd0, STALL_COUNT}, 32'hFFFF);
        repeat (5) cycle();
        chk("sat_hold", {16'd0, STALL_COUNT}, 32'hFFFF);
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
        chk("sat_rst_stall", {16'd0, STALL_COUNT}, 32'd0);
        chk("sat_rst_data", OUT_DATA, RST_VAL);
        chk("sat_rst_valid", {31'd0, OUT_VALID}, 32'd0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
